// File: rtl/huffman_ac_decode_ctrl.sv
// AC Huffman decode sequencer for one 8x8 block: grows a candidate code bit by bit,
// queries the external LUT, gathers magnitude bits and emits (index, value) events.
module huffman_ac_decode_ctrl #(
  parameter int COEFF_WIDTH  = 12,
  parameter int MAX_CODE_LEN = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic                          bit_in,
  input  logic                          bit_valid_in,
  output logic                          bit_ready_out,
  output logic [15:0]                   lut_code_out,
  output logic [4:0]                    lut_len_out,
  output logic                          lut_enable_out,
  input  logic                          lut_valid_in,
  input  logic [4:0]                    lut_codesize_in,
  input  logic [4:0]                    lut_size_in,
  input  logic [4:0]                    lut_run_in,
  output logic                          coeff_valid_out,
  input  logic                          coeff_ready_in,
  output logic [5:0]                    coeff_index_out,
  output logic signed [COEFF_WIDTH-1:0] coeff_value_out,
  output logic                          eob_out,
  output logic                          block_done_out,
  output logic                          error_out,
  output logic                          busy_out
);

  localparam int MW = COEFF_WIDTH - 1;
  localparam logic [COEFF_WIDTH-1:0] C_ONE = {{(COEFF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [4:0] MAX_LEN_C  = 5'(MAX_CODE_LEN);
  localparam logic [4:0] MAX_SIZE_C = 5'(MW);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GET   = 3'd1,
    S_LOOK  = 3'd2,
    S_CHECK = 3'd3,
    S_MAG   = 3'd4,
    S_EMIT  = 3'd5,
    S_ERROR = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            code_q, code_d;
  logic [4:0]             len_q, len_d;
  logic [5:0]             index_q, index_d;
  logic [4:0]             size_q, size_d;
  logic [MW-1:0]          mag_q, mag_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [COEFF_WIDTH-1:0] value_q, value_d;
  logic                   eob_q, eob_d;
  logic                   done_q, done_d;
  logic                   bit_ready_q, bit_ready_d;
  logic                   lut_enable_q, lut_enable_d;
  logic                   coeff_valid_q, coeff_valid_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;

  logic                   bit_hs_s;
  logic                   coeff_hs_s;
  logic [6:0]             idx_run_s;
  logic [6:0]             idx_zrl_s;
  logic [MW-1:0]          mag_shift_s;
  logic [COEFF_WIDTH-1:0] ext_s;
  logic [COEFF_WIDTH-1:0] msb_sel_s;
  logic [COEFF_WIDTH-1:0] ones_s;
  logic [4:0]             cnt_inc_s;

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    len_d     = len_q;
    index_d   = index_q;
    size_d    = size_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    eob_d     = eob_q;
    done_d    = 1'b0;

    bit_hs_s    = bit_ready_q & bit_valid_in;
    coeff_hs_s  = coeff_valid_q & coeff_ready_in;
    idx_run_s   = {1'b0, index_q} + {2'b00, lut_run_in};
    idx_zrl_s   = {1'b0, index_q} + 7'd16;
    mag_shift_s = (mag_q << 1) | {{(MW-1){1'b0}}, bit_in};
    ext_s       = {1'b0, mag_shift_s};
    msb_sel_s   = C_ONE << (size_q - 5'd1);
    ones_s      = (C_ONE << size_q) - C_ONE;
    cnt_inc_s   = cnt_q + 5'd1;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_in) begin
          index_d = 6'd1;
          code_d  = 16'd0;
          len_d   = 5'd0;
          eob_d   = 1'b0;
          state_d = S_GET;
        end else begin
          state_d = state_q;
        end
      end
      S_GET: begin
        if (bit_hs_s) begin
          code_d  = {code_q[14:0], bit_in};
          len_d   = len_q + 5'd1;
          state_d = S_LOOK;
        end else begin
          state_d = S_GET;
        end
      end
      S_LOOK: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // A hit whose reported length disagrees with our own is a corrupt table.
        if (lut_valid_in && (lut_codesize_in != len_q)) begin
          state_d = S_ERROR;
        end else if (lut_valid_in) begin
          size_d = lut_size_in;
          code_d = 16'd0;
          len_d  = 5'd0;
          if (lut_size_in == 5'd0) begin
            if (lut_run_in == 5'd0) begin
              eob_d   = 1'b1;
              value_d = {COEFF_WIDTH{1'b0}};
              state_d = S_EMIT;
            end else if (lut_run_in == 5'd15) begin
              if (idx_zrl_s > 7'd63) begin
                state_d = S_ERROR;
              end else begin
                index_d = idx_zrl_s[5:0];
                state_d = S_GET;
              end
            end else begin
              state_d = S_ERROR;
            end
          end else if ((idx_run_s > 7'd63) || (lut_size_in > MAX_SIZE_C)) begin
            state_d = S_ERROR;
          end else begin
            index_d = idx_run_s[5:0];
            mag_d   = {MW{1'b0}};
            cnt_d   = 5'd0;
            state_d = S_MAG;
          end
        end else if (len_q == MAX_LEN_C) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_GET;
        end
      end
      S_MAG: begin
        if (bit_hs_s) begin
          mag_d = mag_shift_s;
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == size_q) begin
            // Leading magnitude bit 0 encodes a negative value: v = m - (2^size - 1).
            if ((ext_s & msb_sel_s) != {COEFF_WIDTH{1'b0}}) begin
              value_d = ext_s;
            end else begin
              value_d = ext_s - ones_s;
            end
            eob_d   = 1'b0;
            state_d = S_EMIT;
          end else begin
            state_d = S_MAG;
          end
        end else begin
          state_d = S_MAG;
        end
      end
      S_EMIT: begin
        if (coeff_hs_s) begin
          eob_d = 1'b0;
          if (eob_q || (index_q == 6'd63)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            index_d = index_q + 6'd1;
            state_d = S_GET;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bit_ready_d   = (state_d == S_GET) || (state_d == S_MAG);
    lut_enable_d  = (state_d == S_LOOK);
    coeff_valid_d = (state_d == S_EMIT);
    error_d       = (state_d == S_ERROR);
    busy_d        = (state_d != S_IDLE) && (state_d != S_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      code_q        <= 16'd0;
      len_q         <= 5'd0;
      index_q       <= 6'd0;
      size_q        <= 5'd0;
      mag_q         <= {MW{1'b0}};
      cnt_q         <= 5'd0;
      value_q       <= {COEFF_WIDTH{1'b0}};
      eob_q         <= 1'b0;
      done_q        <= 1'b0;
      bit_ready_q   <= 1'b0;
      lut_enable_q  <= 1'b0;
      coeff_valid_q <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      len_q         <= len_d;
      index_q       <= index_d;
      size_q        <= size_d;
      mag_q         <= mag_d;
      cnt_q         <= cnt_d;
      value_q       <= value_d;
      eob_q         <= eob_d;
      done_q        <= done_d;
      bit_ready_q   <= bit_ready_d;
      lut_enable_q  <= lut_enable_d;
      coeff_valid_q <= coeff_valid_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  assign bit_ready_out   = bit_ready_q;
  assign lut_code_out    = code_q;
  assign lut_len_out     = len_q;
  assign lut_enable_out  = lut_enable_q;
  assign coeff_valid_out = coeff_valid_q;
  assign coeff_index_out = index_q;
  assign coeff_value_out = value_q;
  assign eob_out         = eob_q;
  assign block_done_out  = done_q;
  assign error_out       = error_q;
  assign busy_out        = busy_q;

endmodule

// File: tb/tb_huffman_ac_decode_ctrl.sv
// Directed bench for huffman_ac_decode_ctrl: bit source, luminance AC LUT responder,
// and an event scoreboard checked with immediate assertions.
module tb_huffman_ac_decode_ctrl;

  localparam int CW = 12;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          bit_in;
  logic          bit_valid_in;
  logic          bit_ready_out;
  logic [15:0]   lut_code_out;
  logic [4:0]    lut_len_out;
  logic          lut_enable_out;
  logic          lut_valid_in;
  logic [4:0]    lut_codesize_in;
  logic [4:0]    lut_size_in;
  logic [4:0]    lut_run_in;
  logic          coeff_valid_out;
  logic          coeff_ready_in;
  logic [5:0]    coeff_index_out;
  logic [CW-1:0] coeff_value_out;
  logic          eob_out;
  logic          block_done_out;
  logic          error_out;
  logic          busy_out;

  huffman_ac_decode_ctrl #(.COEFF_WIDTH(CW), .MAX_CODE_LEN(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .bit_in(bit_in), .bit_valid_in(bit_valid_in), .bit_ready_out(bit_ready_out),
    .lut_code_out(lut_code_out), .lut_len_out(lut_len_out), .lut_enable_out(lut_enable_out),
    .lut_valid_in(lut_valid_in), .lut_codesize_in(lut_codesize_in),
    .lut_size_in(lut_size_in), .lut_run_in(lut_run_in),
    .coeff_valid_out(coeff_valid_out), .coeff_ready_in(coeff_ready_in),
    .coeff_index_out(coeff_index_out), .coeff_value_out(coeff_value_out),
    .eob_out(eob_out), .block_done_out(block_done_out),
    .error_out(error_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { int idx; int val; bit eob; } ev_t;

  ev_t  exp_q[$];
  bit   bits_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   rand_gate = 1'b0;
  bit   done_pending;
  bit   took;
  ev_t  mon_e;
  logic [15:0] pend;
  logic [15:0] cur;
  logic [CW-1:0] ev_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      $error("%s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++) bits_q.push_back(s[i] == 8'h31);
  endtask

  task automatic push_ev(input int idx, input int val, input bit eob);
    ev_t e;
    e.idx = idx; e.val = val; e.eob = eob;
    exp_q.push_back(e);
  endtask

  // Subset of the standard luminance AC table: {hit, run, size, codesize}.
  function automatic logic [15:0] lut_lookup(input logic [15:0] code, input logic [4:0] len);
    case ({len, code})
      {5'd2,  16'b00}:          return {1'b1, 5'd0,  5'd1, 5'd2};
      {5'd2,  16'b01}:          return {1'b1, 5'd0,  5'd2, 5'd2};
      {5'd3,  16'b100}:         return {1'b1, 5'd0,  5'd3, 5'd3};
      {5'd4,  16'b1010}:        return {1'b1, 5'd0,  5'd0, 5'd4};
      {5'd4,  16'b1011}:        return {1'b1, 5'd0,  5'd4, 5'd4};
      {5'd4,  16'b1100}:        return {1'b1, 5'd1,  5'd1, 5'd4};
      {5'd5,  16'b11010}:       return {1'b1, 5'd0,  5'd5, 5'd5};
      {5'd5,  16'b11011}:       return {1'b1, 5'd1,  5'd2, 5'd5};
      {5'd5,  16'b11100}:       return {1'b1, 5'd2,  5'd1, 5'd5};
      {5'd6,  16'b111010}:      return {1'b1, 5'd3,  5'd1, 5'd6};
      {5'd6,  16'b111011}:      return {1'b1, 5'd4,  5'd1, 5'd6};
      {5'd11, 16'b11111111001}: return {1'b1, 5'd15, 5'd0, 5'd11};
      default:                  return 16'd0;
    endcase
  endfunction

  // LUT responder: answer is presented for the cycle after the enable.
  initial begin
    lut_valid_in = 1'b0; lut_run_in = 5'd0; lut_size_in = 5'd0; lut_codesize_in = 5'd0;
    pend = 16'd0;
    forever begin
      @(negedge clk_in);
      {lut_valid_in, lut_run_in, lut_size_in, lut_codesize_in} = pend;
      pend = lut_enable_out ? lut_lookup(lut_code_out, lut_len_out) : 16'd0;
    end
  end

  // Bit source: presents the queue head, optionally with random valid gaps.
  initial begin
    bit_valid_in = 1'b0; bit_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bits_q.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) begin
        bit_valid_in = 1'b1; bit_in = bits_q[0];
      end else begin
        bit_valid_in = 1'b0; bit_in = 1'b0;
      end
      took = bit_valid_in && bit_ready_out;
      @(posedge clk_in);
      if (took) void'(bits_q.pop_front());
    end
  end

  // Scoreboard monitor and block_done pulse check.
  initial begin
    done_pending = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk_in);
      check("block_done", block_done_out, done_pending);
      done_pending = 1'b0;
      if (coeff_valid_out && coeff_ready_in) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          ev_val = mon_e.val[CW-1:0];
          check("index", coeff_index_out, mon_e.idx);
          check("value", coeff_value_out, ev_val);
          check("eob", eob_out, mon_e.eob);
          done_pending = mon_e.eob || (mon_e.idx == 63);
        end
      end
    end
  end

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_in); #1;
      if (exp_q.size() == 0 && bits_q.size() == 0 && !busy_out) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
    check({tag, "_noerr"}, error_out, 0);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, bit_ready_out, 0);
    check({tag, "_lut_en"}, lut_enable_out, 0);
    check({tag, "_code"}, lut_code_out, 0);
    check({tag, "_len"}, lut_len_out, 0);
    check({tag, "_valid"}, coeff_valid_out, 0);
    check({tag, "_index"}, coeff_index_out, 0);
    check({tag, "_value"}, coeff_value_out, 0);
    check({tag, "_eob"}, eob_out, 0);
    check({tag, "_done"}, block_done_out, 0);
    check({tag, "_error"}, error_out, 0);
    check({tag, "_busy"}, busy_out, 0);
  endtask

  initial begin
    bit ok;
    rst_in = 1'b1; start_in = 1'b0; coeff_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    rst_in = 1'b0;
    mon_en = 1'b1;

    // 0/1 +1 then EOB
    push_bits("001");  push_ev(1, 1, 1'b0);
    push_bits("1010"); push_ev(2, 0, 1'b1);
    pulse_start();
    wait_idle("blk_basic", 200);

    // negative magnitudes
    push_bits("0100");   push_ev(1, -3, 1'b0);
    push_bits("100011"); push_ev(2, -4, 1'b0);
    push_bits("1010");   push_ev(3, 0, 1'b1);
    pulse_start();
    wait_idle("blk_neg", 300);

    // two ZRLs skip 32 positions
    push_bits("11111111001");
    push_bits("11111111001");
    push_bits("001");  push_ev(33, 1, 1'b0);
    push_bits("1010"); push_ev(34, 0, 1'b1);
    pulse_start();
    wait_idle("blk_zrl", 400);

    // full block ends at index 63 with no EOB
    for (int i = 1; i <= 63; i++) begin
      push_bits("001"); push_ev(i, 1, 1'b0);
    end
    pulse_start();
    wait_idle("blk_full", 2000);

    // backpressure in EMIT with random bit gaps
    rand_gate = 1'b1;
    coeff_ready_in = 1'b0;
    push_bits("0110");     push_ev(1, 2, 1'b0);
    push_bits("10110111"); push_ev(2, -8, 1'b0);
    push_bits("1010");     push_ev(3, 0, 1'b1);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (coeff_valid_out) begin ok = 1'b1; break; end
      @(posedge clk_in); #1;
    end
    check("emit_reached", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); #1;
      check("hold_valid", coeff_valid_out, 1);
      check("hold_index", coeff_index_out, 1);
      check("hold_value", coeff_value_out, 2);
      check("hold_eob", eob_out, 0);
      check("hold_ready", bit_ready_out, 0);
      check("hold_bits", bits_q.size(), 12);
    end
    coeff_ready_in = 1'b1;
    wait_idle("blk_hold", 600);
    rand_gate = 1'b0;

    // sixteen 1-bits never match
    push_bits("1111111111111111");
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_in); #1;
      if (error_out) begin ok = 1'b1; break; end
    end
    check("err_seen", ok, 1);
    check("err_bits_used", bits_q.size(), 0);
    check("err_busy", busy_out, 0);
    check("err_ready", bit_ready_out, 0);
    repeat (3) @(posedge clk_in);
    #1;
    check("err_sticky", error_out, 1);

    // restart from ERROR
    push_bits("001");  push_ev(1, 1, 1'b0);
    push_bits("1010"); push_ev(2, 0, 1'b1);
    pulse_start();
    check("restart_err_clr", error_out, 0);
    check("restart_busy", busy_out, 1);
    wait_idle("blk_restart", 200);

    // reset in the middle of magnitude collection
    push_bits("010");
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_in); #1;
      if (bits_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("mag_bits_used", ok, 1);
    repeat (2) @(posedge clk_in);
    #1;
    check("mag_waiting", bit_ready_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_all_zero("midrst");
    rst_in = 1'b0;

    push_bits("001");  push_ev(1, 1, 1'b0);
    push_bits("1010"); push_ev(2, 0, 1'b1);
    pulse_start();
    wait_idle("blk_post_rst", 200);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
